// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA/decrypt stage.
package rc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_I,
    READ_I,
    READ_J,
    WRITE_J,
    ADDR_F,
    READ_F,
    WRITE_D
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;

  function automatic logic is_plain(input logic [7:0] b);
    return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
  endfunction

endpackage

// File: rtl/trap_edge.sv
// Rising-edge detector: registers a level input and pulses for one cycle after it goes high.
module trap_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q, sig_qq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      sig_qq <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      sig_qq <= sig_q;
    end
  end

  assign rise_o = sig_q & ~sig_qq;

endmodule

// File: rtl/rc4_decryptor.sv
// RC4 PRGA stage: swaps S-RAM entries per byte and writes keystream XOR ciphertext to decrypted RAM.
// Optional macro RC4_PLAINTEXT_CHECK_EN aborts the pass on the first byte that is not space or a..z.
module rc4_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_LENGTH = 8,
  parameter int MSG_LENGTH = 32,
  parameter int MSG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  finished,
  input  logic [RAM_WIDTH-1:0]  s_ram_out,
  output logic [RAM_LENGTH-1:0] s_address,
  output logic [RAM_WIDTH-1:0]  s_ram_in,
  output logic                  s_write_enable,
  output logic [MSG_ADDR_W-1:0] rom_address,
  input  logic [RAM_WIDTH-1:0]  rom_out,
  output logic [MSG_ADDR_W-1:0] dec_address,
  output logic [RAM_WIDTH-1:0]  dec_data,
  output logic                  dec_write_enable,
  output logic                  key_invalid
);

  localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LENGTH - 1);

  state_t                state_q, state_d;
  logic [RAM_LENGTH-1:0] i_q, i_d, j_q, j_d, s_addr_q, s_addr_d;
  logic [RAM_WIDTH-1:0]  si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;
  logic [RAM_WIDTH-1:0]  s_din_q, s_din_d, dec_data_q, dec_data_d, dec_byte;
  logic [MSG_ADDR_W-1:0] k_q, k_d, rom_addr_q, rom_addr_d, dec_addr_q, dec_addr_d;
  logic                  s_we, dec_we, fin_q, fin_d, start_rise, bad_byte;

  trap_edge u_start_edge (
    .clk    (clk),
    .rst_n  (reset),
    .sig_i  (start),
    .rise_o (start_rise)
  );

  assign dec_byte = f_q ^ enc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      f_q        <= '0;
      enc_q      <= '0;
      s_addr_q   <= '0;
      s_din_q    <= '0;
      rom_addr_q <= '0;
      dec_addr_q <= '0;
      dec_data_q <= '0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      enc_q      <= enc_d;
      s_addr_q   <= s_addr_d;
      s_din_q    <= s_din_d;
      rom_addr_q <= rom_addr_d;
      dec_addr_q <= dec_addr_d;
      dec_data_q <= dec_data_d;
      fin_q      <= fin_d;
    end
  end

  // Address/data outputs are the _d values so they hold their last value when a state leaves them alone.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    enc_d      = enc_q;
    s_addr_d   = s_addr_q;
    s_din_d    = s_din_q;
    rom_addr_d = rom_addr_q;
    dec_addr_d = dec_addr_q;
    dec_data_d = dec_data_q;
    s_we       = 1'b0;
    dec_we     = 1'b0;
    fin_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = ADDR_I;
          i_d     = RAM_LENGTH'(1);
          j_d     = '0;
          k_d     = '0;
        end
      end
      ADDR_I: begin
        s_addr_d = i_q;
        state_d  = READ_I;
      end
      READ_I: begin
        si_d     = s_ram_out;
        j_d      = j_q + RAM_LENGTH'(s_ram_out);
        s_addr_d = j_d;
        state_d  = READ_J;
      end
      READ_J: begin
        sj_d     = s_ram_out;
        s_addr_d = i_q;
        s_din_d  = s_ram_out;
        s_we     = 1'b1;
        state_d  = WRITE_J;
      end
      WRITE_J: begin
        s_addr_d = j_q;
        s_din_d  = si_q;
        s_we     = 1'b1;
        state_d  = ADDR_F;
      end
      ADDR_F: begin
        s_addr_d   = RAM_LENGTH'(si_q) + RAM_LENGTH'(sj_q);
        rom_addr_d = k_q;
        state_d    = READ_F;
      end
      READ_F: begin
        f_d     = s_ram_out;
        enc_d   = rom_out;
        state_d = WRITE_D;
      end
      WRITE_D: begin
        dec_addr_d = k_q;
        dec_data_d = dec_byte;
        dec_we     = 1'b1;
        if ((k_q == K_LAST) || bad_byte) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else begin
          k_d     = k_q + MSG_ADDR_W'(1);
          i_d     = i_q + RAM_LENGTH'(1);
          state_d = ADDR_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_address        = s_addr_d;
  assign s_ram_in         = s_din_d;
  assign s_write_enable   = s_we;
  assign rom_address      = rom_addr_d;
  assign dec_address      = dec_addr_d;
  assign dec_data         = dec_data_d;
  assign dec_write_enable = dec_we;
  assign finished         = fin_q;

`ifdef RC4_PLAINTEXT_CHECK_EN
  logic kinv_q;

  assign bad_byte = !is_plain(dec_byte[7:0]);

  // Sticky until the next start edge so the controller can read it after the finished pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kinv_q <= 1'b0;
    end else if (start_rise) begin
      kinv_q <= 1'b0;
    end else if ((state_q == WRITE_D) && bad_byte) begin
      kinv_q <= 1'b1;
    end
  end

  assign key_invalid = kinv_q;
`else
  assign bad_byte    = 1'b0;
  assign key_invalid = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_decryptor.sv
// Directed bench for rc4_decryptor with behavioural memories and a software RC4 reference.
module tb_rc4_decryptor;

  localparam int MSG = 32;

  typedef struct packed {
    logic [1:0]  s_kind;   // 0 identity, 1 KSA key 00 03 3C, 2 identity with s[1]/s[255] swapped
    logic        hand;
    logic [23:0] rom3;
    logic [23:0] exp3;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       finished, s_write_enable, dec_write_enable, key_invalid;
  logic [7:0] s_ram_out, s_address, s_ram_in, rom_out, dec_data;
  logic [4:0] rom_address, dec_address;

  logic [7:0] sram[256], s_init[256], m_s[256];
  logic [7:0] rom[32], dec_mem[32], exp_pt[32], ks[32];
  int         wr_cnt = 0, fin_cnt = 0;
  int         exp_n, n_cmp = 0, n_bad = 0;
  logic       exp_kinv, kinv_at_fin;
  logic       load_s = 1'b0, clr_log = 1'b0;
  vec_t       vecs[5];

  rc4_decryptor #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_LENGTH(MSG), .MSG_ADDR_W(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .finished         (finished),
    .s_ram_out        (s_ram_out),
    .s_address        (s_address),
    .s_ram_in         (s_ram_in),
    .s_write_enable   (s_write_enable),
    .rom_address      (rom_address),
    .rom_out          (rom_out),
    .dec_address      (dec_address),
    .dec_data         (dec_data),
    .dec_write_enable (dec_write_enable),
    .key_invalid      (key_invalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_s) begin
      for (int x = 0; x < 256; x++) sram[x] <= s_init[x];
    end else if (s_write_enable) begin
      sram[s_address] <= s_ram_in;
    end
    s_ram_out <= sram[s_address];
    rom_out   <= rom[rom_address];
    if (clr_log) begin
      wr_cnt  <= 0;
      fin_cnt <= 0;
    end else begin
      if (dec_write_enable) begin
        dec_mem[dec_address] <= dec_data;
        wr_cnt <= wr_cnt + 1;
      end
      if (finished) fin_cnt <= fin_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preset(input int kind);
    logic [7:0] key[3];
    logic [7:0] t;
    int j;
    key = '{8'h00, 8'h03, 8'h3C};
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    if (kind == 1) begin
      j = 0;
      for (int x = 0; x < 256; x++) begin
        j = (j + s_init[x] + key[x % 3]) % 256;
        t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
      end
    end else if (kind == 2) begin
      s_init[1]   = 8'hFF;
      s_init[255] = 8'h01;
    end
  endtask

  // Textbook RC4 PRGA over a copy of s_init; stops after the first bad byte when the check is built in.
  task automatic run_model(input bit chk_en);
    int i, j;
    logic [7:0] t, kb;
    bit ok;
    m_s = s_init;
    i = 0; j = 0; exp_n = 0; exp_kinv = 1'b0;
    for (int k = 0; k < MSG; k++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      kb = m_s[(m_s[i] + m_s[j]) % 256];
      exp_pt[k] = kb ^ rom[k];
      exp_n++;
      ok = 1'b1;
`ifdef RC4_PLAINTEXT_CHECK_EN
      ok = (exp_pt[k] == 8'h20) || ((exp_pt[k] >= 8'h61) && (exp_pt[k] <= 8'h7A));
`endif
      if (chk_en && !ok) begin
        exp_kinv = 1'b1;
        break;
      end
    end
  endtask

  // ROM whose plaintext is all lowercase, so the pass runs to the end in either build.
  task automatic build_letter_rom();
    for (int k = 0; k < MSG; k++) rom[k] = 8'h00;
    run_model(1'b0);
    ks = exp_pt;
    for (int k = 0; k < MSG; k++) rom[k] = ks[k] ^ (8'h61 + 8'(k % 26));
    run_model(1'b1);
  endtask

  task automatic load_mems();
    @(negedge clk);
    load_s = 1'b1; clr_log = 1'b1;
    @(negedge clk);
    load_s = 1'b0; clr_log = 1'b0;
  endtask

  // fin_edge is the edge index (0 = edge that first samples start high) after which finished is seen.
  task automatic run_pass(output int fin_edge);
    fin_edge = -1;
    kinv_at_fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 7 * MSG + 20; n++) begin
      @(posedge clk); #1;
      if (finished && fin_edge < 0) begin
        fin_edge = n - 1;
        kinv_at_fin = key_invalid;
      end
      if (fin_edge >= 0 && n > fin_edge + 3) break;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int fin_edge);
    int d;
    chk({tag, "_wr_cnt"}, wr_cnt, exp_n);
    chk({tag, "_fin_cnt"}, fin_cnt, 1);
    chk({tag, "_fin_edge"}, fin_edge, 7 * exp_n + 1);
    chk({tag, "_kinv"}, kinv_at_fin, exp_kinv);
    for (int k = 0; k < exp_n; k++) chk($sformatf("%s_byte%0d", tag, k), dec_mem[k], exp_pt[k]);
    d = 0;
    for (int x = 0; x < 256; x++) if (sram[x] !== m_s[x]) d++;
    chk({tag, "_sram_diffs"}, d, 0);
  endtask

  initial begin
    int   fe;
    bit   found;
    vec_t v;

    vecs[0] = '{2'd0, 1'b1, 24'h000000, 24'h020507};
    vecs[1] = '{2'd0, 1'b1, 24'h636466, 24'h616161};
    vecs[2] = '{2'd0, 1'b1, 24'hFF0FA5, 24'hFD0AA2};
    vecs[3] = '{2'd1, 1'b0, 24'h5A3C01, 24'h000000};
    vecs[4] = '{2'd2, 1'b1, 24'h123456, 24'h123751};

    reset = 1'b1; start = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {finished, s_write_enable, dec_write_enable, key_invalid,
                          s_address, s_ram_in, rom_address, dec_address, dec_data}, 64'd0);
    @(negedge clk) reset = 1'b1;

    for (int t = 0; t < 5; t++) begin
      v = vecs[t];
      preset(int'(v.s_kind));
      rom[0] = v.rom3[23:16]; rom[1] = v.rom3[15:8]; rom[2] = v.rom3[7:0];
      for (int k = 3; k < MSG; k++) rom[k] = 8'(k * 37 + 11);
      run_model(1'b1);
      load_mems();
      run_pass(fe);
      check_pass($sformatf("vec%0d", t), fe);
      if (v.hand) begin
        for (int b = 0; b < 3; b++)
          if (b < exp_n) chk($sformatf("vec%0d_hand%0d", t, b), dec_mem[b], v.exp3[23-8*b -: 8]);
      end
    end

    // Asynchronous reset in the middle of byte 10, then a clean re-run.
    preset(1);
    build_letter_rom();
    load_mems();
    @(negedge clk) start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 7 * MSG && !found; n++) begin
      @(posedge clk); #1;
      if (dec_write_enable && dec_address == 5'd9) found = 1'b1;
    end
    chk("rst_reach_k9", found, 1);
    repeat (3) @(posedge clk);
    #1 chk("rst_pre_swe", s_write_enable, 1);
    #1 reset = 1'b0; start = 1'b0;
    #1 chk("rst_async_outputs", {finished, s_write_enable, dec_write_enable, key_invalid,
                                 s_address, s_ram_in, rom_address, dec_address, dec_data}, 64'd0);
    repeat (5) @(posedge clk);
    #1 chk("rst_wr_cnt", wr_cnt, 10);
    @(negedge clk) reset = 1'b1;
    load_mems();
    run_pass(fe);
    check_pass("rerun", fe);

    // start held high for the whole pass with an extra edge while busy.
    preset(1);
    build_letter_rom();
    load_mems();
    @(negedge clk) start = 1'b1;
    for (int n = 1; n <= 7 * MSG + 40; n++) begin
      @(posedge clk); #1;
      if (n == 60) start = 1'b0;
      if (n == 62) start = 1'b1;
    end
    chk("hold_fin_cnt", fin_cnt, 1);
    chk("hold_wr_cnt", wr_cnt, MSG);
    for (int k = 0; k < MSG; k++) chk($sformatf("hold_byte%0d", k), dec_mem[k], exp_pt[k]);
    @(negedge clk) start = 1'b0;

`ifdef RC4_PLAINTEXT_CHECK_EN
    // Byte 1 decrypts to 'A': written, then abort with key_invalid.
    preset(0);
    for (int k = 0; k < MSG; k++) rom[k] = 8'h00;
    rom[0] = 8'h63;
    rom[1] = 8'h44;
    load_mems();
    run_pass(fe);
    chk("kinv_wr_cnt", wr_cnt, 2);
    chk("kinv_byte0", dec_mem[0], 8'h61);
    chk("kinv_byte1", dec_mem[1], 8'h41);
    chk("kinv_fin_edge", fe, 15);
    chk("kinv_flag", kinv_at_fin, 1);
    chk("kinv_fin_cnt", fin_cnt, 1);
    load_mems();
    @(negedge clk) start = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("kinv_clear_on_start", key_invalid, 0);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk); #1;
      if (finished) found = 1'b1;
    end
    chk("kinv_second_finish", found, 1);
    @(negedge clk) start = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
